// File: rtl/clk_div_prog.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | clk_div_prog: runtime-programmable 50%-duty integer clock divider           |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
module clk_div_prog #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div,
  output logic             out,
  output logic             tick,
  output logic [WIDTH-1:0] div_active,
  output logic             running
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] c_one = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_two = WIDTH'(2);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_act_q, div_act_d;
  logic             hi_p_q, hi_p_d;
  logic             tick_q, tick_d;
  logic             run_q, run_d;
  logic             hi_n_q;

  logic [WIDTH-1:0] w_nc;
  logic [WIDTH-1:0] w_half;
  logic [WIDTH-1:0] w_cnt_inc;
  logic             w_last;

  // Divisors below 2 cannot produce a 50% waveform, so they run as divide-by-2.
  assign w_nc      = (div < c_two) ? c_two : div;
  assign w_half    = div_act_q >> 1;
  assign w_cnt_inc = cnt_q + c_one;
  assign w_last    = (cnt_q == (div_act_q - c_one));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_act_d = div_act_q;
    hi_p_d    = hi_p_q;
    tick_d    = tick_q;
    run_d     = run_q;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d   = ST_RUN;
          cnt_d     = '0;
          div_act_d = w_nc;
          hi_p_d    = 1'b1;
          tick_d    = 1'b1;
          run_d     = 1'b1;
        end
      end
      ST_RUN: begin
        if (!w_last) begin
          cnt_d  = w_cnt_inc;
          hi_p_d = (w_cnt_inc < w_half);
          tick_d = 1'b0;
        end else if (en) begin
          cnt_d     = '0;
          div_act_d = w_nc;
          hi_p_d    = 1'b1;
          tick_d    = 1'b1;
        end else begin
          // Stop only at a period boundary so the last period is never truncated.
          state_d = ST_IDLE;
          cnt_d   = '0;
          hi_p_d  = 1'b0;
          tick_d  = 1'b0;
          run_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      div_act_q <= '0;
      hi_p_q    <= 1'b0;
      tick_q    <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_act_q <= div_act_d;
      hi_p_q    <= hi_p_d;
      tick_q    <= tick_d;
      run_q     <= run_d;
    end
  end

  // Half-cycle extension of the high phase for odd divisors.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      hi_n_q <= 1'b0;
    end else begin
      hi_n_q <= hi_p_q & div_act_q[0] & run_q;
    end
  end

  assign out        = hi_p_q | hi_n_q;
  assign tick       = tick_q;
  assign div_active = div_act_q;
  assign running    = run_q;

endmodule
`default_nettype wire
